// File: rtl/core_scheduler_if.sv
// Scheduler-side bundle: dispatcher start/enables, fetch handshake, LSU status,
// per-thread next_pc collection and the state/pc broadcast to thread datapaths.
interface core_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
);
  logic                       start;
  logic [THREADS-1:0]         thread_enable;
  logic                       fetch_req;
  logic                       instr_valid;
  logic                       decoded_ret;
  logic [THREADS-1:0]         lsu_busy;
  logic [THREADS*PC_BITS-1:0] next_pc;
  logic [2:0]                 core_state;
  logic [PC_BITS-1:0]         current_pc;
  logic                       done;
  logic                       diverged;

  modport master (
    input  start, thread_enable, instr_valid, decoded_ret, lsu_busy, next_pc,
    output fetch_req, core_state, current_pc, done, diverged
  );

  modport slave (
    output start, thread_enable, instr_valid, decoded_ret, lsu_busy, next_pc,
    input  fetch_req, core_state, current_pc, done, diverged
  );
endinterface

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences FETCH..UPDATE for all threads, owns the
// shared pc, flags divergence between enabled threads and stops on RET.
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  core_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } state_t;

  state_t             state;
  logic [PC_BITS-1:0] pc_q;
  logic               fetch_req_q;
  logic               done_q;
  logic               diverged_q;

  logic [PC_BITS-1:0] lead_pc;
  logic               lead_found;
  logic               pc_mismatch;

  // The lowest-index enabled thread defines the shared pc; any other enabled
  // thread disagreeing with it marks the block as diverged.
  always_comb begin
    lead_pc     = '0;
    lead_found  = 1'b0;
    pc_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (bus.thread_enable[i]) begin
        if (!lead_found) begin
          lead_pc    = bus.next_pc[i*PC_BITS +: PC_BITS];
          lead_found = 1'b1;
        end else if (bus.next_pc[i*PC_BITS +: PC_BITS] != lead_pc) begin
          pc_mismatch = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc_q        <= '0;
      fetch_req_q <= 1'b0;
      done_q      <= 1'b0;
      diverged_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state       <= ST_FETCH;
            fetch_req_q <= 1'b1;
            pc_q        <= '0;
            diverged_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.instr_valid) begin
            state       <= ST_DECODE;
            fetch_req_q <= 1'b0;
          end
        end
        ST_DECODE:  state <= ST_REQUEST;
        ST_REQUEST: state <= ST_WAIT;
        // LSU activity of threads outside the block must not stall the core.
        ST_WAIT: begin
          if ((bus.lsu_busy & bus.thread_enable) == '0) begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: state <= ST_UPDATE;
        ST_UPDATE: begin
          if (bus.decoded_ret || (bus.thread_enable == '0)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state       <= ST_FETCH;
            fetch_req_q <= 1'b1;
            pc_q        <= lead_pc;
            if (pc_mismatch) begin
              diverged_q <= 1'b1;
            end
          end
        end
        // A fresh launch requires the dispatcher to drop start first.
        ST_DONE: begin
          if (!bus.start) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_state = state;
  assign bus.current_pc = pc_q;
  assign bus.fetch_req  = fetch_req_q;
  assign bus.done       = done_q;
  assign bus.diverged   = diverged_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: stimulus queues the expected state trace,
// a negedge monitor checks every state change against it.
module tb_core_scheduler;

  localparam int THREADS = 4;
  localparam int PC_BITS = 8;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [7:0] pc;
    logic       fr;
    logic       dn;
    logic       dv;
    int         prev;
  } exp_t;

  logic clock;
  logic reset;

  core_scheduler_if #(.THREADS(THREADS), .PC_BITS(PC_BITS)) bus ();

  core_scheduler #(.THREADS(THREADS), .PC_BITS(PC_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         compared = 0;
  int         errors   = 0;
  logic [2:0] last_state = S_IDLE;
  int         dwell = 0;
  logic [7:0] model_pc = 8'h00;
  logic       model_dv = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: each state change consumes one expected entry; dwell
  // is the number of cycles spent in the state being left.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      last_state = S_IDLE;
      dwell      = 0;
    end else if (bus.core_state != last_state) begin
      compared++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_transition: got state %b, required no transition", bus.core_state);
      end else begin
        e = exp_q.pop_front();
        if (bus.core_state !== e.st || bus.current_pc !== e.pc || bus.fetch_req !== e.fr ||
            bus.done !== e.dn || bus.diverged !== e.dv || (e.prev != 0 && dwell != e.prev)) begin
          errors++;
          $display("[TB] FAIL %s: got st=%b pc=%h fr=%b done=%b dv=%b dwell=%0d, required st=%b pc=%h fr=%b done=%b dv=%b dwell=%0d",
                   e.name, bus.core_state, bus.current_pc, bus.fetch_req, bus.done, bus.diverged, dwell,
                   e.st, e.pc, e.fr, e.dn, e.dv, e.prev);
        end
      end
      last_state = bus.core_state;
      dwell      = 1;
    end else begin
      dwell++;
    end
  end

  task automatic push_exp(input string name, input logic [2:0] st, input logic [7:0] pc,
                          input logic fr, input logic dn, input logic dv, input int prev);
    exp_t e;
    e.name = name; e.st = st; e.pc = pc; e.fr = fr; e.dn = dn; e.dv = dv; e.prev = prev;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [2:0] st, input logic [7:0] pc,
                              input logic fr, input logic dn, input logic dv);
    compared++;
    if (bus.core_state !== st || bus.current_pc !== pc || bus.fetch_req !== fr ||
        bus.done !== dn || bus.diverged !== dv) begin
      errors++;
      $display("[TB] FAIL %s: got st=%b pc=%h fr=%b done=%b dv=%b, required st=%b pc=%h fr=%b done=%b dv=%b",
               name, bus.core_state, bus.current_pc, bus.fetch_req, bus.done, bus.diverged,
               st, pc, fr, dn, dv);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string what);
    int n = 0;
    while (bus.core_state !== s && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (bus.core_state !== s) begin
      compared++;
      errors++;
      $display("[TB] FAIL timeout_%s: got state %b, required %b", what, bus.core_state, s);
    end
  endtask

  task automatic launch(input logic [3:0] en);
    push_exp("launch_fetch", S_FETCH, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    model_pc = 8'h00;
    model_dv = 1'b0;
    bus.thread_enable = en;
    bus.start = 1'b1;
    wait_state(S_FETCH, "launch");
  endtask

  // Runs one instruction from FETCH to the closing UPDATE edge.
  task automatic apply_stimulus(input string name, input int fetch_delay, input logic [3:0] busy,
                                input int hold, input logic [31:0] npc, input logic ret,
                                input logic to_done, input logic [7:0] exp_pc, input logic exp_dv,
                                input int exp_wait);
    push_exp({name, "_decode"},  S_DECODE,  model_pc, 1'b0, 1'b0, model_dv, fetch_delay + 1);
    push_exp({name, "_request"}, S_REQUEST, model_pc, 1'b0, 1'b0, model_dv, 1);
    push_exp({name, "_wait"},    S_WAIT,    model_pc, 1'b0, 1'b0, model_dv, 1);
    push_exp({name, "_execute"}, S_EXECUTE, model_pc, 1'b0, 1'b0, model_dv, exp_wait);
    push_exp({name, "_update"},  S_UPDATE,  model_pc, 1'b0, 1'b0, model_dv, 1);
    if (to_done)
      push_exp({name, "_done"},  S_DONE,  exp_pc, 1'b0, 1'b1, exp_dv, 1);
    else
      push_exp({name, "_fetch"}, S_FETCH, exp_pc, 1'b1, 1'b0, exp_dv, 1);
    model_pc = exp_pc;
    model_dv = exp_dv;

    wait_state(S_FETCH, {name, "_fetch"});
    repeat (fetch_delay) begin
      @(posedge clock);
      #1;
    end
    bus.instr_valid = 1'b1;
    wait_state(S_DECODE, {name, "_decode"});
    bus.instr_valid = 1'b0;
    wait_state(S_REQUEST, {name, "_request"});
    bus.lsu_busy = busy;
    wait_state(S_WAIT, {name, "_wait"});
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock);
        #1;
      end
      bus.lsu_busy = '0;
    end
    wait_state(S_UPDATE, {name, "_update"});
    bus.next_pc = npc;
    bus.decoded_ret = ret;
    @(posedge clock);
    #1;
    bus.decoded_ret = 1'b0;
    bus.lsu_busy = '0;
  endtask

  task automatic end_block(input int hold);
    wait_state(S_DONE, "end_block");
    repeat (hold) begin
      @(posedge clock);
      #1;
    end
    push_exp("back_to_idle", S_IDLE, model_pc, 1'b0, 1'b0, model_dv, hold + 1);
    bus.start = 1'b0;
    wait_state(S_IDLE, "idle");
  endtask

  initial begin
    logic [31:0] npc_a;
    logic [31:0] npc_b;
    npc_a = {8'h20, 8'h11, 8'h11, 8'h33};
    npc_b = {8'h20, 8'h12, 8'h11, 8'h33};

    reset = 1'b0;
    bus.start = 1'b0;
    bus.thread_enable = 4'b0000;
    bus.instr_valid = 1'b0;
    bus.decoded_ret = 1'b0;
    bus.lsu_busy = 4'b0000;
    bus.next_pc = '0;
    #3;
    check_output("reset_values", S_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] block 1: basic sequence, fetch stall, lsu stall, ret");
    bus.next_pc = {4{8'h01}};
    launch(4'b1111);
    apply_stimulus("b1i1", 0, 4'b0000, 0, {4{8'h01}}, 1'b0, 1'b0, 8'h01, 1'b0, 1);
    apply_stimulus("b1i2", 3, 4'b0100, 4, {4{8'h01}}, 1'b0, 1'b0, 8'h01, 1'b0, 5);
    bus.thread_enable = 4'b1011;
    apply_stimulus("b1i3", 0, 4'b0100, 0, {4{8'h01}}, 1'b1, 1'b1, 8'h01, 1'b0, 1);
    end_block(3);

    $display("[TB] block 2: lowest enabled thread and divergence");
    launch(4'b0110);
    apply_stimulus("b2i1", 0, 4'b0000, 0, npc_a, 1'b0, 1'b0, 8'h11, 1'b0, 1);
    apply_stimulus("b2i2", 0, 4'b0000, 0, npc_b, 1'b0, 1'b0, 8'h11, 1'b1, 1);
    apply_stimulus("b2i3", 0, 4'b0000, 0, npc_a, 1'b0, 1'b0, 8'h11, 1'b1, 1);
    apply_stimulus("b2i4", 0, 4'b0000, 0, npc_a, 1'b1, 1'b1, 8'h11, 1'b1, 1);
    end_block(0);

    $display("[TB] block 3: relaunch clears divergence, pc wrap");
    launch(4'b0001);
    apply_stimulus("b3i1", 1, 4'b0001, 2, {4{8'hFF}}, 1'b0, 1'b0, 8'hFF, 1'b0, 3);
    apply_stimulus("b3i2", 0, 4'b1110, 0, {4{8'h00}}, 1'b0, 1'b0, 8'h00, 1'b0, 1);
    apply_stimulus("b3i3", 0, 4'b0000, 0, {4{8'h00}}, 1'b1, 1'b1, 8'h00, 1'b0, 1);
    end_block(1);

    $display("[TB] block 4: no enabled threads terminates at update");
    launch(4'b0000);
    apply_stimulus("b4i1", 0, 4'b1111, 0, {4{8'h55}}, 1'b0, 1'b1, 8'h00, 1'b0, 1);
    end_block(0);

    $display("[TB] async reset mid-wait");
    launch(4'b0001);
    push_exp("rw_decode",  S_DECODE,  8'h00, 1'b0, 1'b0, 1'b0, 1);
    push_exp("rw_request", S_REQUEST, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    push_exp("rw_wait",    S_WAIT,    8'h00, 1'b0, 1'b0, 1'b0, 1);
    bus.instr_valid = 1'b1;
    wait_state(S_DECODE, "rw_decode");
    bus.instr_valid = 1'b0;
    wait_state(S_REQUEST, "rw_request");
    bus.lsu_busy = 4'b0001;
    wait_state(S_WAIT, "rw_wait");
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_mid_wait", S_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.lsu_busy = 4'b0000;
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] async reset mid-fetch");
    launch(4'b0001);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_mid_fetch", S_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    compared++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
